// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: opcodes, states and datapath select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        JAL       = 4'd10
    } state_t;

    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer (master) and the MIPS datapath (slave).
interface multicycle_control_if #(parameter int OPW = 6);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           pc_write;
    logic           ir_write;
    logic           iord;
    logic           mem_read;
    logic           mem_write;
    logic [1:0]     mem_to_reg;
    logic [1:0]     reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           instr_done;
    logic           illegal_op;
    logic [3:0]     state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: fetch/decode/execute/memory/writeback FSM with memory-ready stalls.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op;

    assign op        = bus.opcode;
    assign bus.state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                if      (op == OP_RTYPE)             state_d = R_EXEC;
                else if (op == OP_LW || op == OP_SW) state_d = MEM_ADDR;
                else if (op == OP_BEQ)               state_d = BRANCH;
                else if (op == OP_J)                 state_d = JUMP;
                else if (op == OP_JAL)               state_d = JAL;
                else                                 state_d = FETCH;
            end
            MEM_ADDR:  state_d = (op == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = bus.mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = bus.mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    state_d = R_WB;
            default:   state_d = FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = WB_ALUOUT;
        bus.reg_dst    = DST_RT;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ALUB_B;
        bus.alu_op     = ALUOP_ADD;
        bus.pc_source  = PCSRC_ALU;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ALUB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b  = ALUB_IMM_SH;
                bus.illegal_op = !(op == OP_RTYPE || op == OP_LW || op == OP_SW ||
                                   op == OP_BEQ || op == OP_J || op == OP_JAL);
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUB_IMM;
            end
            MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = WB_MDR;
                bus.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RD;
                bus.instr_done = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = ALUOP_SUB;
                bus.pc_source  = PCSRC_ALUOUT;
                bus.pc_write   = bus.zero;
                bus.instr_done = 1'b1;
            end
            JUMP: begin
                bus.pc_source  = PCSRC_JUMP;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
            end
            JAL: begin
                // PC already holds PC+4, so it is the link value written to $31
                bus.pc_source  = PCSRC_JUMP;
                bus.pc_write   = 1'b1;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RA;
                bus.mem_to_reg = WB_PC;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons the instruction: no strobe or write may escape this cycle
        if (reset) begin
            bus.pc_write   = 1'b0;
            bus.ir_write   = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.reg_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors queued and checked mid-cycle.
module tb_multicycle_control;

    typedef logic [22:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;
    vec_t expq[$];

    multicycle_control_if #(.OPW(6)) bus ();

    multicycle_control #(.OPW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Spec-level view of what each state must drive, expected state supplied by the caller
    function automatic vec_t model(logic [3:0] s, logic rst, logic [5:0] op, logic z, logic mr);
        logic pcw = 0, irw = 0, iord = 0, mrd = 0, mwr = 0, rw = 0, srca = 0, done = 0, ill = 0;
        logic [1:0] m2r = 0, dst = 0, srcb = 0, aop = 0, pcs = 0;
        case (s)
            4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin srcb = 2'b11;
                         ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                            6'b000100, 6'b000010, 6'b000011}); end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 2'b01; done = 1; end
            4'd5:  begin mwr = 1; iord = 1; done = mr; end
            4'd6:  begin srca = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; dst = 2'b01; done = 1; end
            4'd8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; pcw = z; done = 1; end
            4'd9:  begin pcs = 2'b10; pcw = 1; done = 1; end
            4'd10: begin pcs = 2'b10; pcw = 1; rw = 1; dst = 2'b10; m2r = 2'b10; done = 1; end
            default: ;
        endcase
        if (rst) begin pcw = 0; irw = 0; mrd = 0; mwr = 0; rw = 0; done = 0; ill = 0; end
        return {s, pcw, irw, iord, mrd, mwr, m2r, dst, rw, srca, srcb, aop, pcs, done, ill};
    endfunction

    function automatic vec_t observe();
        return {bus.state, bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op};
    endfunction

    // Called just after a rising edge; drives inputs, queues expectation, checks at the falling edge
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic z, input logic mr, input logic [3:0] exp_state);
        vec_t got, want;
        reset         = rst;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        expq.push_back(model(exp_state, rst, op, z, mr));
        @(negedge clk);
        want = expq.pop_front();
        got  = observe();
        total++;
        step_no++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%h expected=%h (state obs=%0d exp=%0d)",
                   tag, step_no, got, want, got[22:19], want[22:19]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode    = 6'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // reset held 3 cycles
        cyc("reset",     1, 6'b000000, 0, 1, 4'd0);
        cyc("reset",     1, 6'b000000, 0, 1, 4'd0);
        cyc("reset",     1, 6'b000000, 0, 1, 4'd0);
        // R-type: 4 cycles
        cyc("r_fetch",   0, 6'b000000, 1, 1, 4'd0);
        cyc("r_decode",  0, 6'b000000, 1, 1, 4'd1);
        cyc("r_exec",    0, 6'b000000, 1, 1, 4'd6);
        cyc("r_wb",      0, 6'b000000, 1, 1, 4'd7);
        // lw with two wait states in MEM_READ: 7 cycles
        cyc("lw_fetch",  0, 6'b100011, 0, 1, 4'd0);
        cyc("lw_decode", 0, 6'b100011, 0, 0, 4'd1);
        cyc("lw_addr",   0, 6'b100011, 1, 0, 4'd2);
        cyc("lw_wait",   0, 6'b100011, 0, 0, 4'd3);
        cyc("lw_wait",   0, 6'b100011, 1, 0, 4'd3);
        cyc("lw_read",   0, 6'b100011, 0, 1, 4'd3);
        cyc("lw_wb",     0, 6'b100011, 0, 0, 4'd4);
        // beq taken then not taken
        cyc("beq1_f",    0, 6'b000100, 1, 1, 4'd0);
        cyc("beq1_d",    0, 6'b000100, 1, 0, 4'd1);
        cyc("beq1_br",   0, 6'b000100, 1, 0, 4'd8);
        cyc("beq0_f",    0, 6'b000100, 0, 1, 4'd0);
        cyc("beq0_d",    0, 6'b000100, 0, 1, 4'd1);
        cyc("beq0_br",   0, 6'b000100, 0, 1, 4'd8);
        // jal, then illegal opcode, then j
        cyc("jal_f",     0, 6'b000011, 0, 1, 4'd0);
        cyc("jal_d",     0, 6'b000011, 0, 1, 4'd1);
        cyc("jal_x",     0, 6'b000011, 0, 1, 4'd10);
        cyc("ill_f",     0, 6'b111111, 0, 1, 4'd0);
        cyc("ill_d",     0, 6'b111111, 0, 1, 4'd1);
        cyc("j_f",       0, 6'b000010, 0, 1, 4'd0);
        cyc("j_d",       0, 6'b000010, 0, 1, 4'd1);
        cyc("j_x",       0, 6'b000010, 0, 1, 4'd9);
        // sw with a fetch wait, then reset during a MEM_WRITE wait
        cyc("sw_fwait",  0, 6'b101011, 0, 0, 4'd0);
        cyc("sw_f",      0, 6'b101011, 0, 1, 4'd0);
        cyc("sw_d",      0, 6'b101011, 0, 1, 4'd1);
        cyc("sw_addr",   0, 6'b101011, 0, 1, 4'd2);
        cyc("sw_wait",   0, 6'b101011, 0, 0, 4'd5);
        cyc("sw_rst",    1, 6'b101011, 0, 0, 4'd5);
        cyc("post_rst",  0, 6'b101011, 0, 1, 4'd0);
        // clean sw: 4 cycles
        cyc("sw2_d",     0, 6'b101011, 0, 1, 4'd1);
        cyc("sw2_addr",  0, 6'b101011, 0, 1, 4'd2);
        cyc("sw2_wr",    0, 6'b101011, 0, 1, 4'd5);
        cyc("sw2_next",  0, 6'b000000, 0, 1, 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS core. It replaces single-cycle opcode decode with a state machine that drives a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback steps. It supports R-type, lw, sw, beq, j and jal, and stalls on a memory-ready handshake. It sits between the instruction register's opcode field and every datapath mux and enable.

## Interface
Parameters
- `OPW`, default 6: opcode width.

Ports
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: synchronous, active-high.
- `opcode` input, OPW: IR[31:26], valid from DECODE onward.
- `zero` input, 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` input, 1: memory completes the current access this cycle.
- `pc_write` output, 1: PC load enable.
- `ir_write` output, 1: IR load enable.
- `iord` output, 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` / `mem_write` output, 1 each: memory strobes.
- `mem_to_reg` output, 2: writeback data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `reg_dst` output, 2: write register select; 00 = rt, 01 = rd, 10 = $31.
- `reg_write` output, 1: register file write enable.
- `alu_src_a` output, 1: ALU A select; 0 = PC, 1 = A register.
- `alu_src_b` output, 2: ALU B select; 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op` output, 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_source` output, 2: PC source select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` output, 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` output, 1: one-cycle pulse on an unsupported opcode.
- `state` output, 4: current state, for debug.

## Operation
- States and encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, JAL=10. Encodings 11–15 are unreachable and go to FETCH.
- Outputs are decoded combinationally from `state`, gated by `mem_ready` and `zero` as listed below. Any signal not listed for a state is 0.
- **FETCH:** mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - any other opcode → FETCH, with illegal_op=1 this cycle.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** mem_read=1, iord=1. Waits on mem_ready, then goes to MEM_WB.
- **MEM_WB:** reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Goes to FETCH.
- **MEM_WRITE:** mem_write=1, iord=1; instr_done=mem_ready. Waits on mem_ready, then goes to FETCH.
- **R_EXEC:** alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- **R_WB:** reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Goes to FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero, instr_done=1. Goes to FETCH.
- **JUMP:** pc_source=10, pc_write=1, instr_done=1. Goes to FETCH.
- **JAL:** pc_source=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1. Goes to FETCH.
  - Writeback data is the PC value, which already holds PC+4 from FETCH.
  - The register write and PC load both commit at the same edge.

## Timing
- **Reset:** while `reset`=1, every enable and strobe output is forced to 0 combinationally. The state register loads FETCH at the clock edge.
  - The first fetch is issued in the cycle after `reset` deasserts.
  - Reset mid-instruction abandons the instruction; no write is committed in the reset cycle.
- **Latency with zero-wait memory** (cycles from FETCH entry to the instr_done cycle, inclusive):
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq, j, jal: 3
  - illegal opcode: 2, with no instr_done pulse.
- **Wait states:** each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
  - Strobes stay asserted and address selects stay stable during a wait.
  - ir_write and pc_write in FETCH assert only in the mem_ready cycle.
- **Ignored inputs:** `zero` is ignored outside BRANCH; `mem_ready` is ignored outside the three memory states.
- **Pulse rules:** `instr_done` and `illegal_op` are single-cycle and never assert together.

## Structure
- `mips_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL
  - the state enum
  - the select encodings: ALUB_*, PCSRC_*, WB_*, DST_*, ALUOP_*
- Single module, with a next-state process and an output-decode process. No sub-module.

## Test plan
- Reset held 3 cycles → all strobes 0, `state`=0 during reset. Release with mem_ready=1 → mem_read=1, ir_write=1 on the first post-reset cycle.
- opcode=000000, mem_ready=1 → states 0,1,6,7; reg_write=1 with reg_dst=01 in cycle 4; instr_done in cycle 4 only.
- opcode=100011, mem_ready low for 2 cycles in MEM_READ → 7 cycles total; mem_to_reg=01 and reg_write in the last cycle.
- opcode=000100 with zero=1, then with zero=0 → pc_write=1 with pc_source=01 in BRANCH for zero=1; pc_write=0 for zero=0; both take 3 cycles.
- opcode=000011 → JAL state asserts pc_write, reg_write, reg_dst=10, mem_to_reg=10. Then opcode=111111 → illegal_op pulses in DECODE, next state FETCH, no writes.
- Reset asserted during MEM_WRITE with mem_ready=0 → mem_write=0 that cycle; next state FETCH.
